// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, state encoding and MEM/WB bubble values for the memory stage
package pipe_pkg;
   localparam int WORD_W = 32;
   localparam int RN_W   = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   localparam logic              BUBBLE_WREG  = 1'b0;
   localparam logic              BUBBLE_M2REG = 1'b0;
   localparam logic [WORD_W-1:0] BUBBLE_MO    = '0;
   localparam logic [WORD_W-1:0] BUBBLE_ALU   = '0;
   localparam logic [RN_W-1:0]   BUBBLE_RN    = '0;
endpackage

// File: rtl/dff1.sv
// rtl/dff1.sv - 1-bit register with asynchronous active-low clear
module dff1 (
   input  logic clock,
   input  logic resetn,
   input  logic d,
   output logic q
);
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) q <= 1'b0;
      else         q <= d;
   end
endmodule

// File: rtl/dff32.sv
// rtl/dff32.sv - 32-bit register with asynchronous active-low clear
module dff32 (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] d,
   output logic [31:0] q
);
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) q <= 32'd0;
      else         q <= d;
   end
endmodule

// File: rtl/dff5.sv
// rtl/dff5.sv - 5-bit register with asynchronous active-low clear
module dff5 (
   input  logic       clock,
   input  logic       resetn,
   input  logic [4:0] d,
   output logic [4:0] q
);
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) q <= 5'd0;
      else         q <= d;
   end
endmodule

// File: rtl/pipe_mwreg.sv
// rtl/pipe_mwreg.sv - MEM/WB pipeline register; i_bubble loads the bubble values instead of the inputs
module pipe_mwreg
   import pipe_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic              i_bubble,
   input  logic              i_wreg,
   input  logic              i_m2reg,
   input  logic [WORD_W-1:0] i_mo,
   input  logic [WORD_W-1:0] i_alu,
   input  logic [RN_W-1:0]   i_rn,
   output logic              o_wwreg,
   output logic              o_wm2reg,
   output logic [WORD_W-1:0] o_wmo,
   output logic [WORD_W-1:0] o_walu,
   output logic [RN_W-1:0]   o_wrn
);
   logic              w_wreg;
   logic              w_m2reg;
   logic [WORD_W-1:0] w_mo;
   logic [WORD_W-1:0] w_alu;
   logic [RN_W-1:0]   w_rn;

   assign w_wreg  = i_bubble ? BUBBLE_WREG  : i_wreg;
   assign w_m2reg = i_bubble ? BUBBLE_M2REG : i_m2reg;
   assign w_mo    = i_bubble ? BUBBLE_MO    : i_mo;
   assign w_alu   = i_bubble ? BUBBLE_ALU   : i_alu;
   assign w_rn    = i_bubble ? BUBBLE_RN    : i_rn;

   dff1  u_wreg  (.clock(clock), .resetn(resetn), .d(w_wreg),  .q(o_wwreg));
   dff1  u_m2reg (.clock(clock), .resetn(resetn), .d(w_m2reg), .q(o_wm2reg));
   dff32 u_mo    (.clock(clock), .resetn(resetn), .d(w_mo),    .q(o_wmo));
   dff32 u_alu   (.clock(clock), .resetn(resetn), .d(w_alu),   .q(o_walu));
   dff5  u_rn    (.clock(clock), .resetn(resetn), .d(w_rn),    .q(o_wrn));
endmodule

// File: rtl/pipe_mem_stage.sv
// rtl/pipe_mem_stage.sv - M stage: data-memory req/ack access, pipeline stall, MEM/WB load,
// misalignment and timeout detection
module pipe_mem_stage
   import pipe_pkg::*;
#(
   parameter int MAX_WAIT    = 15,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              mwreg,
   input  logic              mm2reg,
   input  logic              mwmem,
   input  logic [WORD_W-1:0] malu,
   input  logic [WORD_W-1:0] mb,
   input  logic [RN_W-1:0]   mrn,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [WORD_W-1:0] dmem_addr,
   output logic [WORD_W-1:0] dmem_wdata,
   input  logic [WORD_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              mem_stall,
   output logic              wwreg,
   output logic              wm2reg,
   output logic [WORD_W-1:0] wmo,
   output logic [WORD_W-1:0] walu,
   output logic [RN_W-1:0]   wrn,
   output logic              mem_err
);
   localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

   mem_state_t        r_state;
   mem_state_t        w_state_nxt;
   logic [7:0]        r_cnt;
   logic              r_req;
   logic              r_we;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_err;

   logic              w_acc;
   logic              w_mis;
   logic              w_timeout;
   logic              w_stall;
   logic              w_bubble;
   logic              w_m2reg_d;
   logic [WORD_W-1:0] w_mo_d;

   assign w_acc     = mm2reg | mwmem;
   assign w_mis     = ALIGN_CHECK & w_acc & (malu[1:0] != 2'b00);
   assign w_timeout = (r_cnt == LP_MAX_WAIT);

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_bubble    = 1'b1;
      w_m2reg_d   = mm2reg & ~mwmem;
      w_mo_d      = '0;
      case (r_state)
         IDLE: begin
            if (!w_acc) begin
               w_bubble = 1'b0;
            end else if (!w_mis) begin
               w_stall     = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               w_bubble    = 1'b0;
               w_mo_d      = mwmem ? '0 : dmem_rdata;
               w_state_nxt = IDLE;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address/data/we are captured only on IDLE->BUSY and held through the access.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_acc && w_mis) begin
                  r_err <= 1'b1;
               end else if (w_acc) begin
                  r_addr  <= malu;
                  r_wdata <= mb;
                  r_we    <= mwmem;
                  r_req   <= 1'b1;
                  r_cnt   <= 8'd0;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  r_req <= 1'b0;
               end else if (w_timeout) begin
                  r_req <= 1'b0;
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_req <= 1'b0;
         endcase
      end
   end

   pipe_mwreg u_mwreg (
      .clock    (clock),
      .resetn   (resetn),
      .i_bubble (w_bubble),
      .i_wreg   (mwreg),
      .i_m2reg  (w_m2reg_d),
      .i_mo     (w_mo_d),
      .i_alu    (malu),
      .i_rn     (mrn),
      .o_wwreg  (wwreg),
      .o_wm2reg (wm2reg),
      .o_wmo    (wmo),
      .o_walu   (walu),
      .o_wrn    (wrn)
   );

   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign mem_stall  = w_stall;
   assign mem_err    = r_err;
endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb/tb_pipe_mem_stage.sv - directed self-checking bench for pipe_mem_stage
module tb_pipe_mem_stage;
   logic        clock = 1'b0;
   logic        resetn;
   logic        mwreg, mm2reg, mwmem;
   logic [31:0] malu, mb;
   logic [4:0]  mrn;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        mem_stall;
   logic        wwreg, wm2reg;
   logic [31:0] wmo, walu;
   logic [4:0]  wrn;
   logic        mem_err;

   int n_chk  = 0;
   int n_pass = 0;

   pipe_mem_stage #(.MAX_WAIT(15), .ALIGN_CHECK(1'b1)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .mwreg      (mwreg),
      .mm2reg     (mm2reg),
      .mwmem      (mwmem),
      .malu       (malu),
      .mb         (mb),
      .mrn        (mrn),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .mem_stall  (mem_stall),
      .wwreg      (wwreg),
      .wm2reg     (wm2reg),
      .wmo        (wmo),
      .walu       (walu),
      .wrn        (wrn),
      .mem_err    (mem_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic inst(input logic wr, input logic m2r, input logic wm,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
      mwreg = wr; mm2reg = m2r; mwmem = wm; malu = alu; mb = b; mrn = rn;
      #2;
   endtask

   initial begin
      resetn = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
      #12;
      check("rst_req",   {31'd0, dmem_req},  32'd0);
      check("rst_wwreg", {31'd0, wwreg},     32'd0);
      check("rst_walu",  walu,               32'd0);
      check("rst_err",   {31'd0, mem_err},   32'd0);
      check("rst_stall", {31'd0, mem_stall}, 32'd0);
      resetn = 1'b1;
      step();

      // ALU pass-through, ack in IDLE ignored
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
      inst(1, 0, 0, 32'h0000_0010, 32'h0, 5'd3);
      check("add_stall", {31'd0, mem_stall}, 32'd0);
      step();
      dmem_ack = 1'b0;
      check("add_walu",  walu,              32'h10);
      check("add_wrn",   {27'd0, wrn},      32'd3);
      check("add_wwreg", {31'd0, wwreg},    32'd1);
      check("add_wmo",   wmo,               32'd0);
      check("add_req",   {31'd0, dmem_req}, 32'd0);

      // Load with ack 3 cycles after req rises: 4 stall cycles
      inst(1, 1, 0, 32'h0000_0100, 32'h0, 5'd7);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("ld_stall%0d", k), {31'd0, mem_stall}, 32'd1);
         step();
         check($sformatf("ld_req%0d", k), {31'd0, dmem_req}, 32'd1);
         check($sformatf("ld_bub%0d", k), {31'd0, wwreg},    32'd0);
      end
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we",   {31'd0, dmem_we}, 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
      check("ld_ack_stall", {31'd0, mem_stall}, 32'd0);
      step();
      dmem_ack = 1'b0; dmem_rdata = '0;
      inst(0, 0, 0, 32'h0, 32'h0, 5'd0);
      check("ld_wmo",    wmo,               32'hDEAD_BEEF);
      check("ld_wm2reg", {31'd0, wm2reg},   32'd1);
      check("ld_wwreg",  {31'd0, wwreg},    32'd1);
      check("ld_wrn",    {27'd0, wrn},      32'd7);
      check("ld_walu",   walu,              32'h100);
      check("ld_req_off",{31'd0, dmem_req}, 32'd0);
      step();

      // Store at 0x204, ack after 2 BUSY cycles
      inst(0, 0, 1, 32'h0000_0204, 32'h1234_5678, 5'd0);
      step();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("st_we%0d", k),    {31'd0, dmem_we}, 32'd1);
         check($sformatf("st_addr%0d", k),  dmem_addr,        32'h204);
         check($sformatf("st_wdata%0d", k), dmem_wdata,       32'h1234_5678);
         check($sformatf("st_stall%0d", k), {31'd0, mem_stall}, 32'd1);
         step();
      end
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      step();
      dmem_ack = 1'b0;
      inst(0, 0, 0, 32'h0, 32'h0, 5'd0);
      check("st_wwreg", {31'd0, wwreg},    32'd0);
      check("st_wmo",   wmo,               32'd0);
      check("st_req",   {31'd0, dmem_req}, 32'd0);
      step();

      // Load+store together is a store; immediate ack (2-cycle access)
      inst(1, 1, 1, 32'h0000_0208, 32'hA5A5_A5A5, 5'd9);
      step();
      dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
      step();
      dmem_ack = 1'b0;
      inst(0, 0, 0, 32'h0, 32'h0, 5'd0);
      check("ls_wm2reg", {31'd0, wm2reg}, 32'd0);
      check("ls_wwreg",  {31'd0, wwreg},  32'd1);
      check("ls_wmo",    wmo,             32'd0);
      check("ls_wrn",    {27'd0, wrn},    32'd9);

      // Misaligned load
      inst(1, 1, 0, 32'h0000_0102, 32'h0, 5'd4);
      check("mis_stall", {31'd0, mem_stall}, 32'd0);
      step();
      check("mis_req",   {31'd0, dmem_req}, 32'd0);
      check("mis_err",   {31'd0, mem_err},  32'd1);
      check("mis_wwreg", {31'd0, wwreg},    32'd0);
      for (int k = 0; k < 10; k++) begin
         inst(1, 0, 0, 32'h20 + k, 32'h0, 5'd1);
         step();
      end
      check("mis_sticky", {31'd0, mem_err}, 32'd1);
      check("mis_walu",   walu,             32'h29);

      // Reset clears error, then timeout
      resetn = 1'b0; #2;
      check("rst2_err", {31'd0, mem_err}, 32'd0);
      resetn = 1'b1;
      inst(1, 1, 0, 32'h0000_0300, 32'h0, 5'd2);
      step();
      for (int k = 0; k < 16; k++) begin
         check($sformatf("to_req%0d", k), {31'd0, dmem_req}, 32'd1);
         check($sformatf("to_stall%0d", k), {31'd0, mem_stall}, (k < 15) ? 32'd1 : 32'd0);
         step();
      end
      inst(0, 0, 0, 32'h0, 32'h0, 5'd0);
      check("to_req_off", {31'd0, dmem_req}, 32'd0);
      check("to_err",     {31'd0, mem_err},  32'd1);
      check("to_wwreg",   {31'd0, wwreg},    32'd0);
      check("to_stall",   {31'd0, mem_stall}, 32'd0);

      // Reset mid-BUSY after a valid writeback
      inst(1, 0, 0, 32'h0000_0044, 32'h0, 5'd6);
      step();
      inst(1, 1, 0, 32'h0000_0400, 32'h0, 5'd5);
      check("mb_walu_pre", walu, 32'h44);
      step();
      step();
      check("mb_req_pre", {31'd0, dmem_req}, 32'd1);
      #2 resetn = 1'b0; #1;
      check("mb_req",   {31'd0, dmem_req}, 32'd0);
      check("mb_wwreg", {31'd0, wwreg},    32'd0);
      check("mb_walu",  walu,              32'd0);
      check("mb_wrn",   {27'd0, wrn},      32'd0);
      check("mb_err",   {31'd0, mem_err},  32'd0);
      inst(0, 0, 0, 32'h0, 32'h0, 5'd0);
      resetn = 1'b1;
      step();
      check("mb_idle_req", {31'd0, dmem_req}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
